// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared encodings and constants for the data-memory port arbiter
package dm_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_e;
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hfffffffc;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, a tie goes to the port that did not go last
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);
  // winner index is only meaningful when any is high
  always_comb begin
    any = req0 | req1;
    winner = (req0 & req1) ? ~last : req1;
  end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one DM port between cpu (0) and aux (1); DM_ARB_PERF_EN adds perf counters
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DM_WORDS  = 4096,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [1:0]       lock_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wdata_i,
  input  logic [1:0][3:0]  byteen_i,
  output logic [1:0]       gnt_o,
  output logic [1:0][31:0] rdata_o,
  output logic [1:0]       rvalid_o,
  output logic [1:0]       err_o,
  output logic             cpu_stall,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_byteen,
  input  logic [31:0]      mem_rdata
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_beats0,
  output logic [31:0]      perf_beats1,
  output logic [31:0]      perf_conflict
`endif
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  arb_state_e state_q, state_d;
  logic last_q, last_d, owned, o, beat, oor, rel, pick_last, win, any;
  logic [BW-1:0] burst_q, burst_d;
  logic [1:0] rvalid_q, rvalid_d, err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [31:0] rd;
  // grant, release decision and the memory-side mux of the current owner
  always_comb begin
    owned = state_q != IDLE;
    o = state_q == OWN1;
    gnt_o = {state_q == OWN1 && req_i[1], state_q == OWN0 && req_i[0]};
    beat = |gnt_o;
    oor = {1'b0, addr_i[o]} >= ADDR_LIMIT;
    rel = owned && !(beat && lock_i[o] && burst_q < BURST_LAST);
    pick_last = rel ? o : last_q;
    cpu_stall = req_i[0] && !gnt_o[0];
    mem_addr = owned ? (addr_i[o] & ADDR_ALIGN_MASK) : '0;
    mem_wdata = owned ? wdata_i[o] : '0;
    mem_byteen = (beat && !oor) ? byteen_i[o] : BYTEEN_NONE;
  end
  rr_pick2 u_pick (
    .req0  (req_i[0]),
    .req1  (req_i[1]),
    .last  (pick_last),
    .winner(win),
    .any   (any)
  );
  // next owner, burst tracking and the one-cycle read/ack return
  always_comb begin
    state_d = (owned && !rel) ? state_q : (any ? (win ? OWN1 : OWN0) : IDLE);
    last_d = rel ? o : last_q;
    burst_d = rel ? '0 : (owned ? burst_q + 1'b1 : burst_q);
    rd = (oor || byteen_i[o] != BYTEEN_NONE) ? '0 : mem_rdata;
    rvalid_d = gnt_o;
    err_d = gnt_o & {2{oor}};
    rdata_d[0] = gnt_o[0] ? rd : '0;
    rdata_d[1] = gnt_o[1] ? rd : '0;
  end
  // state registers; reset drops any in-flight beat and lets the cpu win the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      burst_q <= '0;
      rvalid_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      burst_q <= burst_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign rvalid_o = rvalid_q;
  assign err_o = err_q;
  assign rdata_o = rdata_q;
`ifdef DM_ARB_PERF_EN
  logic [31:0] beats0_q, beats0_d, beats1_q, beats1_d, conflict_q, conflict_d;
  // saturating event counters
  always_comb begin
    beats0_d = beats0_q + {31'd0, gnt_o[0] && beats0_q != '1};
    beats1_d = beats1_q + {31'd0, gnt_o[1] && beats1_q != '1};
    conflict_d = conflict_q + {31'd0, &req_i && conflict_q != '1};
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      beats0_q <= '0;
      beats1_q <= '0;
      conflict_q <= '0;
    end else begin
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
      conflict_q <= conflict_d;
    end
  end
  assign perf_beats0 = beats0_q;
  assign perf_beats1 = beats1_q;
  assign perf_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed tests plus a cycle-by-cycle ownership model of dm_port_arbiter
module tb_dm_port_arbiter;
  localparam int unsigned DM_WORDS = 4096;
  localparam int unsigned MAX_BURST = 4;
  localparam logic [31:0] LIM = 32'(DM_WORDS * 4);
  logic clk = 0, reset = 1;
  logic [1:0] req = '0, lock = '0;
  logic [1:0][31:0] addr = '0, wdata = '0;
  logic [1:0][3:0] be = '0;
  logic [1:0] gnt, rvalid, err;
  logic [1:0][31:0] rdata;
  logic stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_byteen;
`ifdef DM_ARB_PERF_EN
  logic [31:0] pb0, pb1, pc;
`endif
  logic [31:0] mem [0:1023];
  logic [31:0] shadow [0:1023];
  int n_chk = 0, n_fail = 0;
  bit armed = 0, log_en = 0;
  bit glog[$];
  logic [3:0] cap_be;
  logic [31:0] cap_addr;
  int owner = -1, last = 1, streak = 0;
  bit g, keep, bad;
  logic [1:0] e_rv = '0, e_err = '0, eg;
  logic [1:0][31:0] e_rd = '0;
  logic [3:0] ebe;
  logic [31:0] ea, ewd;
  int w0, w1, wd;

  dm_port_arbiter #(.DM_WORDS(DM_WORDS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req_i(req), .lock_i(lock), .addr_i(addr), .wdata_i(wdata),
    .byteen_i(be), .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid), .err_o(err),
    .cpu_stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_EN
    , .perf_beats0(pb0), .perf_beats1(pb1), .perf_conflict(pc)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++) if (mem_byteen[b]) mem[mem_addr[11:2]][8*b+:8] = mem_wdata[8*b+:8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port, how many beats it has taken, what returns next cycle
  always @(posedge clk) begin
    if (reset) begin
      owner = -1; last = 1; streak = 0; e_rv = '0; e_err = '0; e_rd = '0;
    end else begin
      e_rv = '0; e_err = '0; e_rd = '0;
      g = owner >= 0 && req[owner];
      if (g) begin
        bad = addr[owner] >= LIM;
        e_rv[owner] = 1'b1;
        e_err[owner] = bad;
        if (!bad && be[owner] == 4'b0) e_rd[owner] = shadow[addr[owner][11:2]];
        if (!bad)
          for (int b = 0; b < 4; b++)
            if (be[owner][b]) shadow[addr[owner][11:2]][8*b+:8] = wdata[owner][8*b+:8];
      end
      if (owner < 0) begin
        if (req[0] && req[1]) owner = 1 - last;
        else if (req[0]) owner = 0;
        else if (req[1]) owner = 1;
      end else begin
        keep = g && lock[owner] && (streak + 1 < int'(MAX_BURST));
        if (keep) streak++;
        else begin
          last = owner; streak = 0;
          if (req[1-owner]) owner = 1 - owner;
          else if (!req[owner]) owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      eg = '0; ebe = '0; ea = '0; ewd = '0;
      if (owner >= 0) begin
        eg[owner] = req[owner];
        ea = addr[owner] & 32'hfffffffc;
        ewd = wdata[owner];
        if (req[owner] && addr[owner] < LIM) ebe = be[owner];
      end
      chk("gnt", gnt, eg);
      chk("cpu_stall", stall, req[0] & ~eg[0]);
      chk("mem_byteen", mem_byteen, ebe);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ewd);
      chk("rvalid", rvalid, e_rv);
      chk("err", err, e_err);
      chk("rdata", rdata, e_rd);
    end
    if (log_en && |gnt) glog.push_back(gnt[1]);
  end

  task automatic do_beat(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic lk, output int w);
    req[k] = 1; lock[k] = lk; addr[k] = a; wdata[k] = d; be[k] = b; w = 0;
    @(negedge clk);
    while (!gnt[k] && w < 40) begin w++; @(negedge clk); end
    if (!gnt[k]) chk("gnt_timeout", gnt[k], 1);
    cap_be = mem_byteen; cap_addr = mem_addr;
    @(posedge clk); #1;
    req[k] = 0; lock[k] = 0; be[k] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] log_val();
    logic [31:0] v = '0;
    foreach (glog[i]) v = {v[30:0], glog[i]};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'(i) * 32'h11111111; shadow[i] = mem[i]; end
    mem[4] = 32'hdeadbeef; shadow[4] = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1 reset = 0; armed = 1;
    @(negedge clk);
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_rvalid", rvalid, 2'b00);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_byteen", mem_byteen, 4'b0);
    idle(1);
    // 1: cpu read alone
    do_beat(0, 32'h10, 32'h0, 4'b0000, 0, w0);
    chk("t1_stall_cycles", w0, 1);
    @(negedge clk);
    chk("t1_rvalid0", rvalid[0], 1);
    chk("t1_rdata0", rdata[0], 32'hdeadbeef);
    idle(2);
    // 2: ties from reset alternate
    reset = 1; idle(1); reset = 0;
    glog.delete(); log_en = 1;
    fork
      begin do_beat(0, 32'h20, 0, 0, 0, w0); do_beat(0, 32'h24, 0, 0, 0, wd); end
      begin do_beat(1, 32'h30, 0, 0, 0, w1); do_beat(1, 32'h34, 0, 0, 0, wd); end
    join
    chk("t2_cpu_wait", w0, 1);
    chk("t2_aux_wait", w1, 2);
    idle(2);
    do_beat(0, 32'h28, 0, 0, 0, wd);
    idle(2);
    fork
      do_beat(0, 32'h20, 0, 0, 0, w0);
      do_beat(1, 32'h30, 0, 0, 0, w1);
    join
    log_en = 0;
    chk("t2_order_len", glog.size(), 7);
    chk("t2_order", log_val(), 32'b0101010);
    idle(2);
    // 3: aux locked burst capped, cpu gets one beat between
    glog.delete(); log_en = 1;
    fork
      for (int i = 0; i < 10; i++) do_beat(1, 32'h40 + 32'(4 * i), 32'h0, 4'b0, 1, wd);
      begin idle(1); do_beat(0, 32'h10, 0, 0, 0, w0); end
    join
    log_en = 0;
    chk("t3_cpu_wait", w0, 4);
    chk("t3_order_len", glog.size(), 11);
    chk("t3_order", log_val(), 32'b11110111111);
    idle(2);
    // 4: range boundary and out-of-range write
    do_beat(0, 32'h3ffc, 0, 4'b0000, 0, wd);
    @(negedge clk);
    chk("t4_edge_err", err[0], 0);
    chk("t4_edge_rdata", rdata[0], 32'h333332ef);
    idle(1);
    do_beat(0, 32'h4000, 32'hffffffff, 4'b1111, 0, wd);
    chk("t4_oor_byteen", cap_be, 4'b0000);
    @(negedge clk);
    chk("t4_err0", err[0], 1);
    chk("t4_rvalid0", rvalid[0], 1);
    chk("t4_mem_unchanged", mem[0], 32'h0);
    idle(1);
    // 5: byte store
    do_beat(0, 32'h8, 32'h0000ab00, 4'b0010, 0, wd);
    chk("t5_byteen", cap_be, 4'b0010);
    chk("t5_addr", cap_addr, 32'h8);
    @(negedge clk);
    chk("t5_mem_word", mem[2], 32'h2222ab22);
    chk("t5_write_ack_rdata", rdata[0], 32'h0);
    idle(2);
    // 6: reset in the middle of an aux burst
    req[1] = 1; lock[1] = 1; addr[1] = 32'h60; be[1] = 0;
    wd = 0;
    @(negedge clk);
    while (!gnt[1] && wd < 40) begin wd++; @(negedge clk); end
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_beat2_gnt", gnt, 2'b10);
    reset = 1;
    @(posedge clk); #1;
    reset = 0; req[0] = 1; addr[0] = 32'h10;
    @(negedge clk);
    chk("t6_post_gnt", gnt, 2'b00);
    chk("t6_post_rvalid", rvalid, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_cpu_first", gnt, 2'b01);
    @(posedge clk); #1;
    req[0] = 0; lock[1] = 0;
    wd = 0;
    @(negedge clk);
    while (!gnt[1] && wd < 40) begin wd++; @(negedge clk); end
    @(posedge clk); #1;
    req[1] = 0;
    idle(3);
    for (int i = 0; i < 1024; i++) if (mem[i] !== shadow[i]) chk("mem_vs_model", mem[i], shadow[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
